dcache_direct_mapped: RTL and testbench

- Blocking, direct-mapped, write-back, write-allocate data cache between the core's dcache port (addr/re/we/din/dout/stall) and the line-wide main-memory interface.
- Serves one load or store per cycle on hit.
- On a miss it raises stall, evicts the line if dirty, refills it, then replays the access.
- Sits directly downstream of the core's memory stage; its stall freezes every pipeline register in the core.

---
 rtl/dcache_direct_mapped.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped.sv
// Blocking, direct-mapped, write-back, write-allocate data cache between the
// core's memory stage and a line-wide (4 x 32-bit) main-memory port.
// A hit is served in the cycle after the request is registered. A miss raises
// stall, writes back the victim line if it is dirty, refills the line, and
// then replays the held request.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   dcache_addr/re/we/din/dout, stall   core side (we = byte-write mask)
//   mem_req_valid/ready/rw/addr/data    line request (rw=1 write-back)
//   mem_resp_valid/data                 refill line, word 0 in [31:0]
//   stats_clear, hit_count, miss_count  only when DCACHE_STATS_EN is defined
//
// Optional feature macro: DCACHE_STATS_EN (hit/miss counters).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_READY   | lookup of the registered request; hits complete here
// S_WB_REQ  | write-back of the dirty victim line offered to memory
// S_RF_REQ  | refill read request offered to memory
// S_RF_WAIT | waiting for the refill line
// S_REPLAY  | held request re-executed against the fresh line
module dcache_direct_mapped #(
  parameter int LINES      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic                  dcache_re,
  input  logic [3:0]            dcache_we,
  input  logic [31:0]           dcache_din,
  output logic [31:0]           dcache_dout,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-5:0] mem_req_addr,
  output logic [127:0]          mem_req_data,
  input  logic                  mem_resp_valid,
  input  logic [127:0]          mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  input  logic                  stats_clear,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_WIDTH - 4 - IW;

  typedef enum logic [2:0] {
    S_READY, S_WB_REQ, S_RF_REQ, S_RF_WAIT, S_REPLAY
  } state_t;

  state_t state, state_nxt;

  logic [127:0]     data_arr [LINES];
  logic [TW-1:0]    tag_arr  [LINES];
  logic [LINES-1:0] valid_arr;
  logic [LINES-1:0] dirty_arr;

  logic                  req_valid;
  logic [ADDR_WIDTH-1:2] req_addr;
  logic [3:0]            req_we;
  logic [31:0]           req_din;
  logic                  req_load;
  logic                  req_store;
  logic [IW-1:0]         req_idx;
  logic [TW-1:0]         req_tag;
  logic [6:0]            word_lsb;

  logic          hit, lookup, miss, access, refill;
  logic [127:0]  line_rd, line_wr;
  logic [31:0]   word_rd, word_wr;
  logic [31:0]   dout_q;

  // byte offset inside a word is never used; the core only issues aligned words
  logic unused_addr_bits;
  assign unused_addr_bits = ^dcache_addr[1:0];

  assign req_idx   = req_addr[IW+3:4];
  assign req_tag   = req_addr[ADDR_WIDTH-1:IW+4];
  assign word_lsb  = {req_addr[3:2], 5'd0};
  assign req_store = |req_we;

  assign hit    = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
  assign lookup = (state == S_READY) && req_valid;
  assign miss   = lookup && !hit;
  // REPLAY is a guaranteed hit on the line just refilled
  assign access = (lookup && hit) || (state == S_REPLAY);
  assign refill = (state == S_RF_WAIT) && mem_resp_valid;

  assign line_rd = data_arr[req_idx];
  assign word_rd = line_rd[word_lsb +: 32];

  always_comb begin
    word_wr = word_rd;
    for (int b = 0; b < 4; b++) begin
      if (req_we[b]) word_wr[8*b +: 8] = req_din[8*b +: 8];
    end
    line_wr = line_rd;
    line_wr[word_lsb +: 32] = word_wr;
  end

  // the core holds its inputs while stalled, so the request is frozen too
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid <= 1'b0;
    end else if (!stall) begin
      req_valid <= dcache_re || (|dcache_we);
      req_addr  <= dcache_addr[ADDR_WIDTH-1:2];
      req_we    <= dcache_we;
      req_din   <= dcache_din;
      req_load  <= dcache_re && !(|dcache_we);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_arr <= '0;
      dirty_arr <= '0;
    end else if (refill) begin
      valid_arr[req_idx] <= 1'b1;
      dirty_arr[req_idx] <= 1'b0;
    end else if (access && req_store) begin
      dirty_arr[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (refill) begin
        data_arr[req_idx] <= mem_resp_data;
        tag_arr[req_idx]  <= req_tag;
      end else if (access && req_store) begin
        data_arr[req_idx] <= line_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dout_q <= '0;
    else if (access && req_load) dout_q <= word_rd;
  end

  assign dcache_dout = (access && req_load) ? word_rd : dout_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_READY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_READY: begin
        if (miss) begin
          if (valid_arr[req_idx] && dirty_arr[req_idx]) state_nxt = S_WB_REQ;
          else                                          state_nxt = S_RF_REQ;
        end
      end
      S_WB_REQ:  if (mem_req_ready)  state_nxt = S_RF_REQ;
      S_RF_REQ:  if (mem_req_ready)  state_nxt = S_RF_WAIT;
      S_RF_WAIT: if (mem_resp_valid) state_nxt = S_REPLAY;
      S_REPLAY:  state_nxt = S_READY;
      default:   state_nxt = S_READY;
    endcase
  end

  // request fields come from the frozen request and untouched arrays,
  // so they stay stable until the handshake
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    unique case (state)
      S_READY: stall = miss;
      S_WB_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_arr[req_idx], req_idx};
        mem_req_data  = line_rd;
      end
      S_RF_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx};
      end
      S_RF_WAIT: stall = 1'b1;
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // a miss is counted once in its lookup cycle; the replay is not a new access
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup && hit) hit_count  <= hit_count + 32'd1;
      if (miss)          miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped (LINES=64, ADDR_WIDTH=32).
// The reference treats the cache as transparent: loads must return the
// core-visible memory image, and a per-index tag table predicts hit, clean
// miss or dirty miss. A memory responder with a programmable ready delay
// serves the line port. Define DCACHE_STATS_EN to also exercise the counters.
module tb_dcache_direct_mapped;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [31:0]  dcache_addr = '0;
  logic         dcache_re = 1'b0;
  logic [3:0]   dcache_we = '0;
  logic [31:0]  dcache_din = '0;
  logic [31:0]  dcache_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;
`ifdef DCACHE_STATS_EN
  logic         stats_clear = 1'b0;
  logic [31:0]  hit_count, miss_count;
`endif

  dcache_direct_mapped #(.LINES(64), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
`ifdef DCACHE_STATS_EN
    , .stats_clear(stats_clear), .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // backing memory (what the responder holds) and core-visible image
  logic [31:0] mem  [logic [29:0]];
  logic [31:0] gmem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return 32'hC0DE_0000 ^ {2'b00, wa};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    return mem.exists(wa) ? mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] g_rd(input logic [29:0] wa);
    return gmem.exists(wa) ? gmem[wa] : init_word(wa);
  endfunction

  function automatic logic [127:0] g_line(input logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = g_rd({la, 2'(i)});
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_rd({la, 2'(i)});
    return l;
  endfunction

  // ---------------- memory responder ----------------
  int           ready_delay = 0;
  bit           hold_resp = 0;
  int           wb_cnt = 0, rf_cnt = 0;
  logic [27:0]  wb_addr = '0, rf_addr = '0;
  logic [127:0] wb_data = '0;
  bit           armed = 0, req_open = 0, resp_pend = 0;
  int           waitc = 0;
  logic         cap_rw;
  logic [27:0]  cap_addr, resp_addr;
  logic [127:0] cap_data;

  always @(negedge clk) begin
    if (reset) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      armed = 0; req_open = 0; resp_pend = 0; waitc = 0;
    end else begin
      mem_resp_valid = 1'b0;
      if (armed) begin
        armed = 0; req_open = 0; waitc = 0;
        if (cap_rw) begin
          wb_cnt++;
          wb_addr = cap_addr;
          wb_data = cap_data;
          for (int i = 0; i < 4; i++) mem[{cap_addr, 2'(i)}] = cap_data[32*i +: 32];
        end else begin
          rf_cnt++;
          rf_addr = cap_addr;
          resp_pend = 1;
          resp_addr = cap_addr;
        end
      end
      if (resp_pend && !hold_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_line(resp_addr);
        resp_pend = 0;
      end
      mem_req_ready = 1'b0;
      if (req_open) begin
        check("req_valid_held", mem_req_valid, 1'b1);
        check("req_hdr_stable", {mem_req_rw, mem_req_addr}, {cap_rw, cap_addr});
        check("req_data_stable", mem_req_data, cap_data);
      end
      if (mem_req_valid) begin
        if (!req_open) begin
          req_open = 1;
          cap_rw = mem_req_rw; cap_addr = mem_req_addr; cap_data = mem_req_data;
        end
        if (waitc >= ready_delay) begin
          mem_req_ready = 1'b1;
          armed = 1;
        end else begin
          waitc++;
        end
      end
    end
  end

  // ---------------- reference model and compare ----------------
  bit           m_valid [64];
  bit           m_dirty [64];
  logic [21:0]  m_tag   [64];
  bit           infl = 0, c_ld, c_st, c_miss, c_wb, completed;
  logic [29:0]  c_wa;
  logic [31:0]  c_dout, last_dout = '0, w;
  logic [27:0]  c_wbaddr, c_rfaddr;
  logic [127:0] c_wbdata;
  logic [5:0]   s_idx;
  logic [21:0]  s_tag;
  int           c_d, c_base_wb, c_base_rf, stall_cyc = 0, last_stall_cyc = 0, stall_negs = 0;

  always @(negedge clk) begin
    if (reset) begin
      infl = 0;
      last_dout = '0;
      for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    end else begin
      completed = 0;
      if (stall) stall_negs++;
      if (infl) begin
        if (stall) begin
          stall_cyc++;
          if (stall_cyc > 300) begin
            check("miss_timeout", 32'(stall_cyc), 32'd0);
            infl = 0;
          end
        end else begin
          infl = 0;
          completed = 1;
          last_stall_cyc = stall_cyc;
          check("stall_cycles", 32'(stall_cyc),
                c_miss ? 32'(3 + c_d + (c_wb ? 1 + c_d : 0)) : 32'd0);
          check("wb_count", 32'(wb_cnt - c_base_wb), {31'd0, c_wb});
          check("rf_count", 32'(rf_cnt - c_base_rf), {31'd0, c_miss});
          if (c_wb) begin
            check("wb_addr", wb_addr, c_wbaddr);
            check("wb_data", wb_data, c_wbdata);
          end
          if (c_miss) check("rf_addr", rf_addr, c_rfaddr);
          if (c_ld) begin
            check("load_dout", dcache_dout, c_dout);
            last_dout = c_dout;
          end else begin
            check("store_dout_hold", dcache_dout, last_dout);
          end
        end
      end
      if (!stall) begin
        if (!completed) check("dout_hold", dcache_dout, last_dout);
        if (dcache_re || dcache_we != 4'd0) begin
          s_idx = dcache_addr[9:4];
          s_tag = dcache_addr[31:10];
          c_wa  = dcache_addr[31:2];
          c_st  = (dcache_we != 4'd0);
          c_ld  = !c_st;
          c_miss = !(m_valid[s_idx] && m_tag[s_idx] == s_tag);
          c_wb   = c_miss && m_valid[s_idx] && m_dirty[s_idx];
          c_wbaddr = {m_tag[s_idx], s_idx};
          c_rfaddr = {s_tag, s_idx};
          if (c_wb) c_wbdata = g_line(c_wbaddr);
          if (c_miss) begin
            m_valid[s_idx] = 1; m_tag[s_idx] = s_tag; m_dirty[s_idx] = 0;
          end
          if (c_st) begin
            m_dirty[s_idx] = 1;
            w = g_rd(c_wa);
            for (int b = 0; b < 4; b++) if (dcache_we[b]) w[8*b +: 8] = dcache_din[8*b +: 8];
            gmem[c_wa] = w;
          end else begin
            c_dout = g_rd(c_wa);
          end
          c_d = ready_delay;
          c_base_wb = wb_cnt;
          c_base_rf = rf_cnt;
          stall_cyc = 0;
          infl = 1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Tasks start and end at posedge+1 so the compare process sees each
  // request at the negedge before the edge that samples it.
  task automatic issue(input logic [31:0] a, input logic re, input logic [3:0] we,
                       input logic [31:0] d);
    dcache_addr = a; dcache_re = re; dcache_we = we; dcache_din = d;
    for (int k = 0; k <= 400; k++) begin
      @(negedge clk); #1;
      if (!stall) break;
      if (k == 400) check("issue_timeout", stall, 1'b0);
    end
    @(posedge clk); #1;
    dcache_re = 1'b0; dcache_we = 4'd0;
  endtask

  task automatic wait_done();
    for (int k = 0; k <= 400; k++) begin
      @(negedge clk); #1;
      if (!infl && !stall) break;
      if (k == 400) check("done_timeout", infl, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic        re;
    logic [3:0]  we;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [10];
  int   s0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[30'h400 + 30'(i)]  = 32'hA + 32'(i);
      gmem[30'h400 + 30'(i)] = 32'hA + 32'(i);
    end
    tbl[0] = '{32'h0000_0010, 1'b0, 4'hF, 32'h1111_2222};
    tbl[1] = '{32'h0000_0010, 1'b1, 4'h4, 32'hAABB_CCDD};
    tbl[2] = '{32'h0000_0010, 1'b1, 4'h0, 32'h0};
    tbl[3] = '{32'h0000_03F0, 1'b1, 4'h0, 32'h0};
    tbl[4] = '{32'h0000_0410, 1'b1, 4'h0, 32'h0};
    tbl[5] = '{32'h0000_0010, 1'b1, 4'h0, 32'h0};
    tbl[6] = '{32'h0000_0400, 1'b0, 4'h8, 32'hFF00_0000};
    tbl[7] = '{32'h0000_0000, 1'b1, 4'h0, 32'h0};
    tbl[8] = '{32'h0000_0404, 1'b1, 4'h0, 32'h0};
    tbl[9] = '{32'h0000_0400, 1'b1, 4'h0, 32'h0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("reset_stall", stall, 1'b0);
    check("reset_mem_req_valid", mem_req_valid, 1'b0);
    check("reset_dout", dcache_dout, 32'd0);
    @(posedge clk); #1;

    // cold load: clean miss, refill of line 0x100, word 1
    issue(32'h0000_1004, 1'b1, 4'h0, 32'h0);
    wait_done();
    check("cold_dout_lit", dcache_dout, 32'hB);
    check("cold_rf_addr_lit", rf_addr, 28'h000_0100);
    check("cold_no_wb_lit", 32'(wb_cnt), 32'd0);
    check("cold_stall_lit", 32'(last_stall_cyc), 32'd3);

    // back-to-back hits
    s0 = stall_negs;
    issue(32'h0000_1000, 1'b1, 4'h0, 32'h0);
    issue(32'h0000_1008, 1'b1, 4'h0, 32'h0);
    issue(32'h0000_100C, 1'b1, 4'h0, 32'h0);
    wait_done();
    check("hits_dout_lit", dcache_dout, 32'hD);
    check("hits_no_stall_lit", 32'(stall_negs - s0), 32'd0);

    // store hit then load of the same word
    issue(32'h0000_1004, 1'b0, 4'b0011, 32'h1234_5678);
    issue(32'h0000_1004, 1'b1, 4'h0, 32'h0);
    wait_done();
    check("store_merge_lit", dcache_dout, 32'h0000_5678);

    // dirty eviction with a slow memory
    ready_delay = 5;
    issue(32'h0000_1404, 1'b1, 4'h0, 32'h0);
    wait_done();
    check("evict_wb_addr_lit", wb_addr, 28'h000_0100);
    check("evict_wb_word1_lit", wb_data[63:32], 32'h0000_5678);
    check("evict_rf_addr_lit", rf_addr, 28'h000_0140);
    check("evict_stall_lit", 32'(last_stall_cyc), 32'd14);
    check("evict_dout_lit", dcache_dout, 32'hC0DE_0501);

    // reset while waiting for a refill
    ready_delay = 0;
    hold_resp = 1;
    r0 = rf_cnt;
    issue(32'h0000_2004, 1'b1, 4'h0, 32'h0);
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk); #1;
      if (rf_cnt != r0) break;
      if (k == 50) check("rf_wait_timeout", 32'(rf_cnt - r0), 32'd1);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    hold_resp = 0;
    @(negedge clk); #1;
    check("rst_mid_stall", stall, 1'b0);
    check("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    r0 = rf_cnt;
    issue(32'h0000_1004, 1'b1, 4'h0, 32'h0);
    wait_done();
    check("reload_misses_lit", 32'(rf_cnt - r0), 32'd1);
    check("reload_dout_lit", dcache_dout, 32'h0000_5678);

    // mixed vectors: store priority, index 63, aliasing at LINES*16
    ready_delay = 1;
    for (int i = 0; i < 10; i++) issue(tbl[i].a, tbl[i].re, tbl[i].we, tbl[i].d);
    wait_done();
    check("table_last_dout_lit", dcache_dout, 32'hFFDE_0100);

`ifdef DCACHE_STATS_EN
    @(posedge clk); #1 stats_clear = 1'b1;
    @(posedge clk); #1 stats_clear = 1'b0;
    issue(32'h0000_5050, 1'b1, 4'h0, 32'h0);
    issue(32'h0000_5050, 1'b1, 4'h0, 32'h0);
    issue(32'h0000_5054, 1'b1, 4'h0, 32'h0);
    issue(32'h0000_5058, 1'b1, 4'h0, 32'h0);
    wait_done();
    check("stats_hits", hit_count, 32'd3);
    check("stats_misses", miss_count, 32'd1);
    stats_clear = 1'b1;
    @(posedge clk); #1 stats_clear = 1'b0;
    check("stats_hits_cleared", hit_count, 32'd0);
    check("stats_misses_cleared", miss_count, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
